stack_ctrl: RTL and testbench

Multi-cycle stack sequencer for the MiniRISC CPU. The controller FSM raises a stack request for a subroutine call/return or an interrupt entry/exit. This block then arbitrates for the data-memory bus and pushes or pops the return frame (PC, plus the flags byte for interrupts). It owns the stack pointer (SP) and returns the popped PC/flags to the control unit.

---
 rtl/stack_ctrl_pkg.sv | 32 +++
 rtl/stack_ctrl_if.sv | 41 ++++
 rtl/stack_ctrl.sv | 139 +++++++++++++
 tb/tb_stack_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared types and constants for the MiniRISC stack sequencer.
package stack_ctrl_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STATE_W = 3;

  localparam logic [DATA_W-1:0] STACK_BASE_DEF  = 8'hFF;
  localparam logic [DATA_W-1:0] STACK_LIMIT_DEF = 8'h80;

  localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] ST_CHECK = 3'd1;
  localparam logic [STATE_W-1:0] ST_REQ   = 3'd2;
  localparam logic [STATE_W-1:0] ST_XFER  = 3'd3;
  localparam logic [STATE_W-1:0] ST_DONE  = 3'd4;

  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  localparam logic [1:0] FRAME_SUB_BYTES = 2'd1;
  localparam logic [1:0] FRAME_INT_BYTES = 2'd2;

  // Operation attributes latched when a request is accepted.
  typedef struct packed {
    logic push;
    logic frame_int;
  } op_cfg_t;

  function automatic logic [1:0] frame_bytes(input logic frame_int);
    return frame_int ? FRAME_INT_BYTES : FRAME_SUB_BYTES;
  endfunction

endpackage

// File: rtl/stack_ctrl_if.sv
// Controller handshake and data-memory bus seen by the stack sequencer.
interface stack_ctrl_if;
  import stack_ctrl_pkg::*;

  logic              stack_op_ongoing;
  logic              push_or_pop;
  logic              frame_int;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] flags_in;
  logic              stack_op_end;
  logic              stack_err;
  logic [DATA_W-1:0] return_addr;
  logic [DATA_W-1:0] flags_out;
  logic [DATA_W-1:0] sp;
  logic              bus_req;
  logic              bus_grant;
  logic [DATA_W-1:0] mem_addr;
  logic              mem_wr;
  logic              mem_rd;
  logic [DATA_W-1:0] mem_dout;
  logic [DATA_W-1:0] mem_din;
  logic              dbg_sp_wr;
  logic [DATA_W-1:0] dbg_data_in;

  // Controller / arbiter / memory side.
  modport master (
    output stack_op_ongoing, push_or_pop, frame_int, pc_in, flags_in,
    output bus_grant, mem_din, dbg_sp_wr, dbg_data_in,
    input  stack_op_end, stack_err, return_addr, flags_out, sp,
    input  bus_req, mem_addr, mem_wr, mem_rd, mem_dout
  );

  // Stack sequencer side.
  modport slave (
    input  stack_op_ongoing, push_or_pop, frame_int, pc_in, flags_in,
    input  bus_grant, mem_din, dbg_sp_wr, dbg_data_in,
    output stack_op_end, stack_err, return_addr, flags_out, sp,
    output bus_req, mem_addr, mem_wr, mem_rd, mem_dout
  );

endinterface

// File: rtl/stack_ctrl.sv
// Stack sequencer: checks SP bounds, arbitrates for the data bus and
// pushes/pops 1-byte subroutine or 2-byte interrupt return frames.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter logic [DATA_W-1:0] STACK_BASE  = STACK_BASE_DEF,
  parameter logic [DATA_W-1:0] STACK_LIMIT = STACK_LIMIT_DEF
) (
  input logic         clk,
  input logic         rst,
  stack_ctrl_if.slave bus
);

  localparam int unsigned CHK_W = DATA_W + 1;

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  op_cfg_t            cfg;
  logic               idx;
  logic [DATA_W-1:0]  sp;
  logic [DATA_W-1:0]  return_addr;
  logic [DATA_W-1:0]  flags_out;
  logic               op_end;
  logic               op_err;
  logic               bus_req;

  logic [CHK_W-1:0]   sp_ext;
  logic [CHK_W-1:0]   nbytes_ext;
  logic [DATA_W-1:0]  sp_inc;
  logic [DATA_W-1:0]  sp_dec;
  logic               chk_err;
  logic               last_byte;
  logic               xfer_go;
  logic [DATA_W-1:0]  mem_addr_c;
  logic [DATA_W-1:0]  mem_dout_c;
  logic               mem_wr_c;
  logic               mem_rd_c;

  // Bounds check in 9 bits so SP arithmetic near 8'h00/8'hFF cannot alias.
  always_comb begin
    sp_ext     = CHK_W'(sp);
    nbytes_ext = CHK_W'(frame_bytes(cfg.frame_int));
    sp_inc     = DATA_W'(sp + DATA_W'(1));
    sp_dec     = DATA_W'(sp - DATA_W'(1));
    if (cfg.push == OP_PUSH) begin
      chk_err = (sp_ext + CHK_W'(1)) < (CHK_W'(STACK_LIMIT) + nbytes_ext);
    end else begin
      chk_err = (sp_ext + nbytes_ext) > CHK_W'(STACK_BASE);
    end
    last_byte = (idx == cfg.frame_int);
  end

  // Next state and same-cycle memory strobes; reset squashes any access in flight.
  always_comb begin
    state_next = state;
    xfer_go    = (state == ST_XFER) && bus.bus_grant && !rst;
    mem_wr_c   = 1'b0;
    mem_rd_c   = 1'b0;
    mem_addr_c = '0;
    mem_dout_c = '0;

    case (state)
      ST_IDLE:  if (bus.stack_op_ongoing) state_next = ST_CHECK;
      ST_CHECK: state_next = chk_err ? ST_DONE : ST_REQ;
      ST_REQ:   if (bus.bus_grant) state_next = ST_XFER;
      ST_XFER:  if (xfer_go && last_byte) state_next = ST_DONE;
      ST_DONE:  if (!bus.stack_op_ongoing) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase

    if (xfer_go) begin
      if (cfg.push == OP_PUSH) begin
        mem_wr_c   = 1'b1;
        mem_addr_c = sp;
        mem_dout_c = idx ? bus.flags_in : bus.pc_in;
      end else begin
        mem_rd_c   = 1'b1;
        mem_addr_c = sp_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cfg         <= '0;
      idx         <= 1'b0;
      sp          <= STACK_BASE;
      return_addr <= '0;
      flags_out   <= '0;
      op_end      <= 1'b0;
      op_err      <= 1'b0;
      bus_req     <= 1'b0;
    end else begin
      state   <= state_next;
      op_end  <= (state_next == ST_DONE) && (state != ST_DONE);
      op_err  <= (state == ST_CHECK) && chk_err;
      bus_req <= (state_next == ST_REQ) || (state_next == ST_XFER);

      case (state)
        ST_IDLE: begin
          if (bus.stack_op_ongoing) begin
            cfg.push      <= bus.push_or_pop;
            cfg.frame_int <= bus.frame_int;
            idx           <= 1'b0;
          end else if (bus.dbg_sp_wr) begin
            sp <= bus.dbg_data_in;
          end
        end
        ST_XFER: begin
          if (xfer_go) begin
            idx <= idx + 1'b1;
            if (cfg.push == OP_PUSH) begin
              sp <= sp_dec;
            end else begin
              sp <= sp_inc;
              // Interrupt frames pop flags first, then the PC.
              if (cfg.frame_int && !idx) flags_out <= bus.mem_din;
              else                       return_addr <= bus.mem_din;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stack_op_end = op_end;
  assign bus.stack_err    = op_err;
  assign bus.return_addr  = return_addr;
  assign bus.flags_out    = flags_out;
  assign bus.sp           = sp;
  assign bus.bus_req      = bus_req;
  assign bus.mem_addr     = mem_addr_c;
  assign bus.mem_wr       = mem_wr_c;
  assign bus.mem_rd       = mem_rd_c;
  assign bus.mem_dout     = mem_dout_c;

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: table of stack operations with a
// result scoreboard, plus a hand-written mid-frame reset sequence.
module tb_stack_ctrl;

  logic clk;
  logic rst;

  stack_ctrl_if bus();

  stack_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        push;
    logic        fint;
    logic [7:0]  pc;
    logic [7:0]  flags;
    logic        dbg_en;
    logic [7:0]  dbg_sp;
    logic        noise;
    logic [63:0] mask;
    int          hold;
    logic        exp_err;
    logic [7:0]  exp_sp;
    logic [7:0]  exp_ret;
    logic [7:0]  exp_flg;
    int          exp_lat;
    int          exp_nwr;
    int          exp_nrd;
    logic        mchk;
    logic [7:0]  maddr;
    logic [7:0]  mval;
  } vec_t;

  typedef struct packed {
    logic       err;
    logic [7:0] sp;
    logic [7:0] ret;
    logic [7:0] flg;
  } exp_t;

  localparam int NVEC = 14;

  logic [7:0] mem [256] = '{default: 8'h00};
  exp_t       sb[$];
  exp_t       e;
  vec_t       tbl [NVEC];
  int         n_checks = 0;
  int         n_err    = 0;
  int         n_wr     = 0;
  int         n_rd     = 0;
  int         n_end    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory model: write on the clock, read data in the same cycle.
  assign bus.mem_din = mem[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_wr) begin
      mem[bus.mem_addr] <= bus.mem_dout;
      n_wr++;
    end
    if (bus.mem_rd) n_rd++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: compare each completion against the oldest expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.stack_err) check("err_with_end", 32'(bus.stack_op_end), 32'd1);
      if (bus.stack_op_end) begin
        n_end++;
        check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("stack_err", 32'(bus.stack_err), 32'(e.err));
          check("sp", 32'(bus.sp), 32'(e.sp));
          check("return_addr", 32'(bus.return_addr), 32'(e.ret));
          check("flags_out", 32'(bus.flags_out), 32'(e.flg));
        end
      end
    end
  end

  function automatic vec_t mk(
    input logic push, input logic fint, input logic [7:0] pc, input logic [7:0] flags,
    input logic dbg_en, input logic [7:0] dbg_sp, input logic noise,
    input logic [63:0] mask, input int hold,
    input logic err, input logic [7:0] sp, input logic [7:0] ret, input logic [7:0] flg,
    input int lat, input int nwr, input int nrd,
    input logic mchk, input logic [7:0] maddr, input logic [7:0] mval);
    vec_t v;
    v.push = push; v.fint = fint; v.pc = pc; v.flags = flags;
    v.dbg_en = dbg_en; v.dbg_sp = dbg_sp; v.noise = noise;
    v.mask = mask; v.hold = hold;
    v.exp_err = err; v.exp_sp = sp; v.exp_ret = ret; v.exp_flg = flg;
    v.exp_lat = lat; v.exp_nwr = nwr; v.exp_nrd = nrd;
    v.mchk = mchk; v.maddr = maddr; v.mval = mval;
    return v;
  endfunction

  task automatic do_op(input vec_t v, input int id);
    int  lat;
    int  nwr0;
    int  nrd0;
    int  nend0;
    bit  seen;
    @(posedge clk); #1;
    if (v.dbg_en) begin
      bus.dbg_sp_wr   = 1'b1;
      bus.dbg_data_in = v.dbg_sp;
      @(posedge clk); #1;
      bus.dbg_sp_wr   = 1'b0;
    end
    sb.push_back('{v.exp_err, v.exp_sp, v.exp_ret, v.exp_flg});
    nwr0  = n_wr;
    nrd0  = n_rd;
    nend0 = n_end;
    bus.stack_op_ongoing = 1'b1;
    bus.push_or_pop      = v.push;
    bus.frame_int        = v.fint;
    bus.pc_in            = v.pc;
    bus.flags_in         = v.flags;
    if (v.noise) begin
      bus.dbg_sp_wr   = 1'b1;
      bus.dbg_data_in = 8'h00;
    end
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 60 && !seen; k++) begin
      @(posedge clk); #1;
      bus.bus_grant = !v.mask[k];
      #1;
      if (v.mask[k]) begin
        check("stall_strobes", 32'({bus.mem_wr, bus.mem_rd}), 32'd0);
        check("stall_bus_req", 32'(bus.bus_req), 32'd1);
      end
      if (bus.stack_op_end) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    check("end_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(v.exp_lat));
    repeat (v.hold) @(posedge clk);
    #1;
    bus.stack_op_ongoing = 1'b0;
    bus.dbg_sp_wr        = 1'b0;
    bus.bus_grant        = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("end_pulses", 32'(n_end - nend0), 32'd1);
    check("writes", 32'(n_wr - nwr0), 32'(v.exp_nwr));
    check("reads", 32'(n_rd - nrd0), 32'(v.exp_nrd));
    if (v.mchk) check($sformatf("mem_%0d", id), 32'(mem[v.maddr]), 32'(v.mval));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  nwr0;
    bit  seen;

    //   push fint pc     flags  dbg  dbgsp  nz mask     hold err sp     ret    flg    lat nwr nrd mchk addr   val
    tbl[0]  = mk(1, 0, 8'h3C, 8'h00, 0, 8'h00, 0, 64'h0,   0, 0, 8'hFE, 8'h00, 8'h00, 4, 1, 0, 1, 8'hFF, 8'h3C);
    tbl[1]  = mk(1, 1, 8'h10, 8'h05, 0, 8'h00, 1, 64'h0,   0, 0, 8'hFC, 8'h00, 8'h00, 5, 2, 0, 1, 8'hFD, 8'h05);
    tbl[2]  = mk(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 64'h0,   0, 0, 8'hFE, 8'h10, 8'h05, 5, 0, 2, 1, 8'hFE, 8'h10);
    tbl[3]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 64'h0,   0, 0, 8'hFF, 8'h3C, 8'h05, 4, 0, 1, 0, 8'h00, 8'h00);
    tbl[4]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 64'h0,   0, 1, 8'hFF, 8'h3C, 8'h05, 2, 0, 0, 0, 8'h00, 8'h00);
    tbl[5]  = mk(1, 1, 8'h10, 8'h05, 1, 8'h80, 0, 64'h0,   0, 1, 8'h80, 8'h3C, 8'h05, 2, 0, 0, 0, 8'h00, 8'h00);
    tbl[6]  = mk(1, 0, 8'hA5, 8'h00, 0, 8'h00, 0, 64'h0,   0, 0, 8'h7F, 8'h3C, 8'h05, 4, 1, 0, 1, 8'h80, 8'hA5);
    tbl[7]  = mk(1, 0, 8'hB6, 8'h00, 0, 8'h00, 0, 64'h0,   0, 1, 8'h7F, 8'h3C, 8'h05, 2, 0, 0, 1, 8'h7F, 8'h00);
    tbl[8]  = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 64'h0,   0, 0, 8'h80, 8'hA5, 8'h05, 4, 0, 1, 0, 8'h00, 8'h00);
    tbl[9]  = mk(0, 1, 8'h00, 8'h00, 1, 8'hFE, 0, 64'h0,   0, 1, 8'hFE, 8'hA5, 8'h05, 2, 0, 0, 0, 8'h00, 8'h00);
    tbl[10] = mk(1, 1, 8'h77, 8'h88, 0, 8'h00, 0, 64'h19C, 0, 0, 8'hFC, 8'hA5, 8'h05, 10, 2, 0, 1, 8'hFD, 8'h88);
    tbl[11] = mk(0, 1, 8'h00, 8'h00, 0, 8'h00, 0, 64'h0,   0, 0, 8'hFE, 8'h77, 8'h88, 5, 0, 2, 1, 8'hFE, 8'h77);
    tbl[12] = mk(1, 0, 8'h5A, 8'h00, 0, 8'h00, 0, 64'h0,   6, 0, 8'hFD, 8'h77, 8'h88, 4, 1, 0, 1, 8'hFE, 8'h5A);
    tbl[13] = mk(0, 0, 8'h00, 8'h00, 0, 8'h00, 0, 64'h0,   0, 0, 8'hFE, 8'h5A, 8'h88, 4, 0, 1, 0, 8'h00, 8'h00);

    rst                  = 1'b1;
    bus.stack_op_ongoing = 1'b0;
    bus.push_or_pop      = 1'b0;
    bus.frame_int        = 1'b0;
    bus.pc_in            = 8'h00;
    bus.flags_in         = 8'h00;
    bus.bus_grant        = 1'b1;
    bus.dbg_sp_wr        = 1'b0;
    bus.dbg_data_in      = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sp", 32'(bus.sp), 32'hFF);
    check("rst_return_addr", 32'(bus.return_addr), 32'h00);
    check("rst_flags_out", 32'(bus.flags_out), 32'h00);
    check("rst_strobes", 32'({bus.bus_req, bus.mem_wr, bus.mem_rd}), 32'd0);
    check("rst_end_err", 32'({bus.stack_op_end, bus.stack_err}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) do_op(tbl[i], i);

    // Reset after byte 0 of an interrupt push: no second write, SP restored.
    @(posedge clk); #1;
    nwr0                 = n_wr;
    bus.stack_op_ongoing = 1'b1;
    bus.push_or_pop      = 1'b1;
    bus.frame_int        = 1'b1;
    bus.pc_in            = 8'h11;
    bus.flags_in         = 8'h22;
    seen                 = 1'b0;
    for (int k = 1; k <= 20 && !seen; k++) begin
      @(posedge clk); #2;
      if (bus.mem_wr) seen = 1'b1;
    end
    check("abort_byte0_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_wr_gated", 32'(bus.mem_wr), 32'd0);
    @(posedge clk); #1;
    rst                  = 1'b0;
    bus.stack_op_ongoing = 1'b0;
    #1;
    check("abort_bus_req", 32'(bus.bus_req), 32'd0);
    check("abort_sp", 32'(bus.sp), 32'hFF);
    repeat (3) @(posedge clk);
    #1;
    check("abort_writes", 32'(n_wr - nwr0), 32'd1);
    check("abort_mem_fe", 32'(mem[8'hFE]), 32'h11);
    check("abort_mem_fd", 32'(mem[8'hFD]), 32'h88);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
